// File: rtl/apb_usrt_master_if.sv
// Command, response and APB signal bundle for apb_usrt_master.
// The master modport is the requester's view; slave is the host/peripheral side.
interface apb_usrt_master_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic              cmd_write;
   logic [ADDR_W-1:0] cmd_addr;
   logic [DATA_W-1:0] cmd_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic              rsp_timeout;
   logic              pSelect;
   logic              pEnable;
   logic              pWrite;
   logic [ADDR_W-1:0] pAddr;
   logic [DATA_W-1:0] pWData;
   logic              pReady;
   logic [DATA_W-1:0] pRData;
   logic              pSlverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pReady, pRData, pSlverr,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output pSelect, pEnable, pWrite, pAddr, pWData
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, pReady, pRData, pSlverr,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  pSelect, pEnable, pWrite, pAddr, pWData
   );
endinterface

// File: rtl/apb_usrt_master.sv
// APB requester: turns single-beat valid/ready commands into SETUP/ACCESS transfers
// and returns read data / slave error / timeout on a one-deep response port.
module apb_usrt_master #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input logic               pClk,
   input logic               pReset,
   apb_usrt_master_if.master bus
);
   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e            r_state, w_state_d;
   logic              r_sel, w_sel_d;
   logic              r_en, w_en_d;
   logic              r_write, w_write_d;
   logic [ADDR_W-1:0] r_addr, w_addr_d;
   logic [DATA_W-1:0] r_wdata, w_wdata_d;
   logic              r_rsp_valid, w_rsp_valid_d;
   logic [DATA_W-1:0] r_rdata, w_rdata_d;
   logic              r_err, w_err_d;
   logic              r_to, w_to_d;
   logic [CNT_W-1:0]  r_cnt, w_cnt_d;
   logic [CNT_W-1:0]  w_cnt_inc;

   assign w_cnt_inc = r_cnt + 1'b1;

   always_ff @(posedge pClk or negedge pReset) begin
      if (!pReset) begin
         r_state     <= StIdle;
         r_sel       <= 1'b0;
         r_en        <= 1'b0;
         r_write     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
         r_to        <= 1'b0;
         r_cnt       <= '0;
      end else begin
         r_state     <= w_state_d;
         r_sel       <= w_sel_d;
         r_en        <= w_en_d;
         r_write     <= w_write_d;
         r_addr      <= w_addr_d;
         r_wdata     <= w_wdata_d;
         r_rsp_valid <= w_rsp_valid_d;
         r_rdata     <= w_rdata_d;
         r_err       <= w_err_d;
         r_to        <= w_to_d;
         r_cnt       <= w_cnt_d;
      end
   end

   always_comb begin
      w_state_d     = r_state;
      w_sel_d       = r_sel;
      w_en_d        = r_en;
      w_write_d     = r_write;
      w_addr_d      = r_addr;
      w_wdata_d     = r_wdata;
      w_rsp_valid_d = r_rsp_valid;
      w_rdata_d     = r_rdata;
      w_err_d       = r_err;
      w_to_d        = r_to;
      w_cnt_d       = r_cnt;
      unique case (r_state)
         StIdle: begin
            if (bus.cmd_valid) begin
               w_state_d = StSetup;
               w_sel_d   = 1'b1;
               w_en_d    = 1'b0;
               w_write_d = bus.cmd_write;
               w_addr_d  = bus.cmd_addr;
               w_wdata_d = bus.cmd_wdata;
            end
         end
         StSetup: begin
            w_state_d = StAccess;
            w_sel_d   = 1'b1;
            w_en_d    = 1'b1;
         end
         StAccess: begin
            // pReady takes priority over a timeout expiring in the same cycle
            if (bus.pReady) begin
               w_state_d     = StResp;
               w_sel_d       = 1'b0;
               w_en_d        = 1'b0;
               w_rsp_valid_d = 1'b1;
               w_err_d       = bus.pSlverr;
               w_to_d        = 1'b0;
               w_rdata_d     = (!r_write && !bus.pSlverr) ? bus.pRData : '0;
            end else if ((TIMEOUT != 0) && (w_cnt_inc == TO_VAL)) begin
               w_state_d     = StResp;
               w_sel_d       = 1'b0;
               w_en_d        = 1'b0;
               w_rsp_valid_d = 1'b1;
               w_err_d       = 1'b1;
               w_to_d        = 1'b1;
               w_rdata_d     = '0;
               w_cnt_d       = w_cnt_inc;
            end else begin
               w_cnt_d = w_cnt_inc;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               w_state_d     = StIdle;
               w_rsp_valid_d = 1'b0;
               w_cnt_d       = '0;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   assign bus.cmd_ready   = (r_state == StIdle);
   assign bus.pSelect     = r_sel;
   assign bus.pEnable     = r_en;
   assign bus.pWrite      = r_write;
   assign bus.pAddr       = r_addr;
   assign bus.pWData      = r_wdata;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_rdata   = r_rdata;
   assign bus.rsp_err     = r_err;
   assign bus.rsp_timeout = r_to;
endmodule

// File: tb/tb_apb_usrt_master.sv
// Directed bench for apb_usrt_master: vector table of single transfers plus
// hand sequences for response backpressure and mid-transfer reset.
module tb_apb_usrt_master;
   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   apb_usrt_master_if #(.ADDR_W(32), .DATA_W(8)) bus ();

   apb_usrt_master #(.ADDR_W(32), .DATA_W(8), .TIMEOUT(4)) dut (
      .pClk   (clk),
      .pReset (rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [7:0]  wdata;
      int          waits;
      logic        slverr;
      logic [7:0]  prdata;
      logic [7:0]  exp_rdata;
      logic        exp_err;
      logic        exp_to;
      int          exp_en;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int en_cycles;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = v.wr;
      bus.cmd_addr  = v.addr;
      bus.cmd_wdata = v.wdata;
      bus.pRData    = v.prdata;
      bus.pSlverr   = v.slverr;
      bus.pReady    = 1'b0;
      chk({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
      tick();
      bus.cmd_valid = 1'b0;
      chk({tag, ".setup"}, {29'd0, bus.pSelect, bus.pEnable, bus.pWrite}, {29'd0, 2'b10, v.wr});
      chk({tag, ".paddr"}, bus.pAddr, v.addr);
      tick();
      chk({tag, ".access"}, {30'd0, bus.pSelect, bus.pEnable}, 32'b11);
      if (v.wr) chk({tag, ".pwdata"}, 32'(bus.pWData), 32'(v.wdata));
      en_cycles = 0;
      while (bus.pEnable && en_cycles < 20) begin
         en_cycles++;
         bus.pReady = (en_cycles == v.waits + 1);
         tick();
         bus.pReady = 1'b0;
      end
      chk({tag, ".en_cycles"}, 32'(en_cycles), 32'(v.exp_en));
      chk({tag, ".resp"}, {28'd0, bus.rsp_valid, bus.pSelect, bus.rsp_err, bus.rsp_timeout},
          {28'd0, 2'b10, v.exp_err, v.exp_to});
      chk({tag, ".rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk({tag, ".idle"}, {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      total = 0;
      bad   = 0;
      // wr addr wdata waits slverr prdata | exp_rdata err to en
      vecs[0] = '{1'b1, 32'h4,  8'hA5, 0,   1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 1};
      vecs[1] = '{1'b0, 32'h8,  8'h00, 3,   1'b0, 8'h3C, 8'h3C, 1'b0, 1'b0, 4};
      vecs[2] = '{1'b0, 32'hC,  8'h00, 1,   1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 2};
      vecs[3] = '{1'b0, 32'h20, 8'h00, 999, 1'b0, 8'h99, 8'h00, 1'b1, 1'b1, 4};
      vecs[4] = '{1'b0, 32'h10, 8'h00, 0,   1'b0, 8'h5A, 8'h5A, 1'b0, 1'b0, 1};
      vecs[5] = '{1'b1, 32'h14, 8'h6E, 2,   1'b1, 8'h11, 8'h00, 1'b1, 1'b0, 3};

      bus.cmd_valid = 1'b0;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = '0;
      bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0;
      bus.pReady    = 1'b0;
      bus.pRData    = '0;
      bus.pSlverr   = 1'b0;
      rst_n = 1'b0;
      #23;
      chk("reset.outs", {26'd0, bus.cmd_ready, bus.pSelect, bus.pEnable, bus.rsp_valid,
          bus.rsp_err, bus.rsp_timeout}, 32'b100000);
      chk("reset.paddr", bus.pAddr, 32'd0);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Response backpressure with a second command waiting
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
      bus.cmd_addr  = 32'h30;
      bus.pRData    = 8'hC7;
      bus.pSlverr   = 1'b0;
      tick();
      tick();
      bus.pReady = 1'b1;
      bus.cmd_addr = 32'h34;
      tick();
      bus.pReady = 1'b0;
      bus.pRData = 8'h00;
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("bp%0d.hold", i), {29'd0, bus.cmd_ready, bus.rsp_valid, bus.pSelect},
             32'b010);
         chk($sformatf("bp%0d.rdata", i), 32'(bus.rsp_rdata), 32'hC7);
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk("bp.handshake", {30'd0, bus.rsp_valid, bus.cmd_ready}, 32'b01);
      tick();
      bus.cmd_valid = 1'b0;
      chk("bp.second_setup", {30'd0, bus.pSelect, bus.pEnable}, 32'b10);
      chk("bp.second_addr", bus.pAddr, 32'h34);
      bus.pRData = 8'h42;
      tick();
      bus.pReady = 1'b1;
      tick();
      bus.pReady = 1'b0;
      chk("bp.second_rdata", {23'd0, bus.rsp_valid, bus.rsp_rdata}, {23'd0, 1'b1, 8'h42});
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;

      // Reset asserted while the transfer sits in ACCESS
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b1;
      bus.cmd_addr  = 32'h40;
      bus.cmd_wdata = 8'h81;
      tick();
      bus.cmd_valid = 1'b0;
      tick();
      chk("rst.in_access", {30'd0, bus.pSelect, bus.pEnable}, 32'b11);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst.async", {28'd0, bus.pSelect, bus.pEnable, bus.rsp_valid, bus.cmd_ready},
          32'b0001);
      #3;
      rst_n = 1'b1;
      tick();
      run_vec('{1'b1, 32'h44, 8'h3E, 1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 2}, "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
